// File: rtl/ioctl_upload_reader.sv
// HPS upload byte reader: pauses the core, fetches bytes from a synchronous RAM and serves them on ioctl_din.
// Optional macro UPLOAD_PAUSE_TIMEOUT_EN adds a pause-ack timeout with sticky timeout_err.
module ioctl_upload_reader #(
  parameter int         ADDR_W       = 10,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         RD_LATENCY   = 1,
  parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAUSE   = 3'd1,
    READY   = 3'd2,
    FETCH   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t              state_r, state_s;
  logic                match_prev_r;
  logic                pend_r, pend_s;
  logic [24:0]         pend_addr_r, pend_addr_s;
  logic                oor_r, oor_s;
  logic [1:0]          lat_cnt_r, lat_cnt_s;
  logic [7:0]          din_r, din_s;
  logic [ADDR_W-1:0]   ram_addr_r, ram_addr_s;
  logic                pause_req_r, pause_req_s;
  logic                busy_r, busy_s;
  logic                ack_go_s;
  logic                fetch_go_s;
  logic                match_s;
  logic [24:0]         svc_addr_s;
  logic                svc_oor_s;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
  logic [15:0]         to_cnt_r, to_cnt_s;
  logic                timeout_err_r, timeout_err_s;
`endif

  assign match_s    = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  // A strobe in the same cycle as service takes priority over the older latched address.
  assign svc_addr_s = ioctl_rd ? ioctl_addr : pend_addr_r;
  assign svc_oor_s  = (svc_addr_s >> ADDR_W) != 25'd0;

  // Next-state and next-output logic for the upload session FSM.
  always_comb begin
    state_s     = state_r;
    pend_s      = pend_r;
    pend_addr_s = pend_addr_r;
    oor_s       = oor_r;
    lat_cnt_s   = lat_cnt_r;
    din_s       = din_r;
    ram_addr_s  = ram_addr_r;
    pause_req_s = pause_req_r;
    busy_s      = busy_r;
    ack_go_s    = 1'b0;
    fetch_go_s  = 1'b0;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
    to_cnt_s      = to_cnt_r;
    timeout_err_s = timeout_err_r;
`endif
    case (state_r)
      IDLE: begin
        if (match_s && !match_prev_r) begin
          state_s     = PAUSE;
          pause_req_s = 1'b1;
          busy_s      = 1'b1;
          pend_s      = 1'b0;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
          to_cnt_s    = 16'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      PAUSE: begin
        ack_go_s = pause_ack;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
        if (!pause_ack) begin
          if (to_cnt_r == 16'hFFFE) begin
            timeout_err_s = 1'b1;
            ack_go_s      = 1'b1;
          end else begin
            to_cnt_s = to_cnt_r + 16'd1;
          end
        end else begin
          to_cnt_s = to_cnt_r;
        end
`endif
        if (ack_go_s) begin
          if (ioctl_rd || pend_r) begin
            fetch_go_s = 1'b1;
          end else begin
            state_s = READY;
          end
        end else if (ioctl_rd) begin
          pend_s      = 1'b1;
          pend_addr_s = ioctl_addr;
        end else begin
          state_s = PAUSE;
        end
      end
      READY: begin
        if (ioctl_rd || pend_r) begin
          fetch_go_s = 1'b1;
        end else begin
          state_s = READY;
        end
      end
      FETCH: begin
        if (ioctl_rd) begin
          pend_s      = 1'b1;
          pend_addr_s = ioctl_addr;
        end else begin
          pend_s = pend_r;
        end
        if (lat_cnt_r == LAT) begin
          din_s   = oor_r ? FILL_BYTE : ram_q;
          state_s = READY;
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end
      RELEASE: begin
        pause_req_s = 1'b0;
        busy_s      = 1'b0;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Out-of-range reads leave ram_addr alone and return FILL_BYTE after the normal latency.
    if (fetch_go_s) begin
      state_s   = FETCH;
      lat_cnt_s = 2'd0;
      pend_s    = 1'b0;
      oor_s     = svc_oor_s;
      if (!svc_oor_s) begin
        ram_addr_s = svc_addr_s[ADDR_W-1:0];
      end else begin
        ram_addr_s = ram_addr_r;
      end
    end else begin
      oor_s = oor_s;
    end

    if ((state_r == PAUSE || state_r == READY || state_r == FETCH) && !match_s) begin
      state_s     = RELEASE;
      pause_req_s = 1'b0;
      pend_s      = 1'b0;
      din_s       = din_r;
      ram_addr_s  = ram_addr_r;
    end else begin
      pause_req_s = pause_req_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= IDLE;
      match_prev_r <= 1'b0;
      pend_r       <= 1'b0;
      pend_addr_r  <= 25'd0;
      oor_r        <= 1'b0;
      lat_cnt_r    <= 2'd0;
      din_r        <= 8'd0;
      ram_addr_r   <= '0;
      pause_req_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
      to_cnt_r      <= 16'd0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      match_prev_r <= match_s;
      pend_r       <= pend_s;
      pend_addr_r  <= pend_addr_s;
      oor_r        <= oor_s;
      lat_cnt_r    <= lat_cnt_s;
      din_r        <= din_s;
      ram_addr_r   <= ram_addr_s;
      pause_req_r  <= pause_req_s;
      busy_r       <= busy_s;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
      to_cnt_r      <= to_cnt_s;
      timeout_err_r <= timeout_err_s;
`endif
    end
  end

  assign ioctl_din = din_r;
  assign ram_addr  = ram_addr_r;
  assign pause_req = pause_req_r;
  assign busy      = busy_r;
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Scoreboard bench for ioctl_upload_reader: expected bytes queued at stimulus time, compared when due.
module tb_ioctl_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_q;
  logic        pause_req;
  logic        pause_ack;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] mem [0:1023];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  ioctl_upload_reader dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ram_addr     (ram_addr),
    .ram_q        (ram_q),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk_sys) ram_q <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    if (a >= 25'd1024) return 8'hFF;
    return mem[a[9:0]];
  endfunction

  task automatic push_exp(input logic [7:0] d, input int due);
    sb_t e;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Read strobe issued in READY: byte due RD_LATENCY+2 = 3 cycles later.
  task automatic rd_strobe(input logic [24:0] a);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    push_exp(exp_byte(a), cyc + 3);
    tick();
    ioctl_rd = 1'b0;
  endtask

  // Scoreboard monitor: compare the head entry on the cycle it falls due.
  always @(negedge clk_sys) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      check("sb_din", {24'd0, ioctl_din}, {24'd0, e.data});
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[10'h001] = 8'h77;
    mem[10'h003] = 8'hA5;
    mem[10'h010] = 8'h3C;
    mem[10'h011] = 8'hC3;
    mem[10'h020] = 8'h42;
    mem[10'h040] = 8'h99;
    mem[10'h041] = 8'h66;
    mem[10'h3FF] = 8'h5E;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd4;
    ioctl_rd = 1'b0; ioctl_addr = 25'd0; pause_ack = 1'b0;
    tick(3);
    check("rst_din", {24'd0, ioctl_din}, 32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_pause_req", {31'd0, pause_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: matching upload, ack after 5 cycles, read 0x003
    ioctl_upload = 1'b1;
    tick();
    check("t1_pause_req", {31'd0, pause_req}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick(4);
    pause_ack = 1'b1;
    tick(2);
    rd_strobe(25'h003);
    tick(4);
    check("t1_busy_hold", {31'd0, busy}, 32'd1);

    // 2: out-of-range reads and upper boundary
    rd_strobe(25'h400);
    tick(4);
    check("t2_ram_addr", {22'd0, ram_addr}, 32'h003);
    rd_strobe(25'h1000003);
    tick(4);
    rd_strobe(25'h3FF);
    tick(4);
    // back-to-back: second strobe lands in FETCH and is served from the pending buffer
    ioctl_rd = 1'b1; ioctl_addr = 25'h040;
    push_exp(exp_byte(25'h040), cyc + 3);
    tick();
    ioctl_addr = 25'h041;
    push_exp(exp_byte(25'h041), cyc + 5);
    tick();
    ioctl_rd = 1'b0;
    tick(6);
    ioctl_upload = 1'b0;
    tick();
    check("t2_rel_pause_req", {31'd0, pause_req}, 32'd0);
    check("t2_rel_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t2_rel_busy_low", {31'd0, busy}, 32'd0);
    check("t2_rel_din", {24'd0, ioctl_din}, 32'h66);
    pause_ack = 1'b0;
    tick(2);

    // 3: strobe during PAUSE, ack 10 cycles later
    ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h010;
    tick();
    ioctl_rd = 1'b0;
    tick(9);
    pause_ack = 1'b1;
    push_exp(8'h3C, cyc + 3);
    tick(5);
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick(3);
    // two strobes in PAUSE: last one wins
    ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h010;
    tick();
    ioctl_addr = 25'h011;
    tick();
    ioctl_rd = 1'b0;
    tick(3);
    pause_ack = 1'b1;
    push_exp(8'hC3, cyc + 3);
    tick(5);
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick(3);

    // 4: non-matching index is ignored
    ioctl_index = 8'd0; ioctl_upload = 1'b1; pause_ack = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(i * 5);
      tick();
      ioctl_rd = 1'b0;
      tick(4);
      check("t4_pause_req", {31'd0, pause_req}, 32'd0);
      check("t4_busy", {31'd0, busy}, 32'd0);
      check("t4_din", {24'd0, ioctl_din}, 32'hC3);
    end
    ioctl_upload = 1'b0; ioctl_index = 8'd4;
    tick(2);

    // 5: upload drops mid-FETCH
    ioctl_upload = 1'b1;
    tick(3);
    ioctl_rd = 1'b1; ioctl_addr = 25'h020;
    tick();
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    tick();
    check("t5_pause_req", {31'd0, pause_req}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t5_busy_low", {31'd0, busy}, 32'd0);
    tick(3);
    check("t5_din_kept", {24'd0, ioctl_din}, 32'hC3);
    // reset while READY
    ioctl_upload = 1'b1;
    tick(3);
    rd_strobe(25'h003);
    tick(4);
    reset = 1'b1;
    tick();
    check("t5_rst_din", {24'd0, ioctl_din}, 32'd0);
    check("t5_rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("t5_rst_pause_req", {31'd0, pause_req}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick(2);

    // 6: pause_ack never arrives
    ioctl_upload = 1'b1;
    tick();
`ifdef UPLOAD_PAUSE_TIMEOUT_EN
    begin
      int n = 0;
      while (timeout_err !== 1'b1 && n < 70000) begin
        tick();
        n++;
      end
      check("t6_timeout_cyc", n, 65535);
      check("t6_timeout_err", {31'd0, timeout_err}, 32'd1);
      tick();
      rd_strobe(25'h001);
      tick(4);
      check("t6_timeout_sticky", {31'd0, timeout_err}, 32'd1);
    end
`else
    ioctl_rd = 1'b1; ioctl_addr = 25'h001;
    tick();
    ioctl_rd = 1'b0;
    tick(300);
    check("t6_pause_req", {31'd0, pause_req}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("t6_din", {24'd0, ioctl_din}, 32'd0);
`endif
    ioctl_upload = 1'b0;
    tick(3);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
